// File: rtl/fifo_flags.sv
// Show-ahead synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_REG_OUT_EN to drive r_data from an output register (capacity 2**W+1).
module fifo_flags #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam int DEPTH = 2**W;
`ifdef FIFO_REG_OUT_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif
  localparam logic [W:0] CAP_C = (W+1)'(CAP);
  localparam logic [W:0] AF_C  = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_C  = (W+1)'(AE_LEVEL);

  logic [B-1:0] mem_r [DEPTH];
  logic [W-1:0] w_ptr_r;
  logic [W-1:0] r_ptr_r;
  logic [W:0]   count_r;
  logic         full_r;
  logic         empty_r;
  logic         almost_full_r;
  logic         almost_empty_r;
  logic         overflow_r;
  logic         underflow_r;

  logic         wr_acc_s;
  logic         rd_acc_s;
  logic         mem_rd_s;
  logic         ovf_evt_s;
  logic         unf_evt_s;
  logic [W:0]   count_next_s;
  logic         empty_next_s;

  // A write while full is only legal when a pop frees the head slot in the same cycle.
  assign wr_acc_s  = wr & (~full_r | rd);
  assign rd_acc_s  = rd & ~empty_r;
  assign ovf_evt_s = wr & full_r & ~rd;
  assign unf_evt_s = rd & empty_r;

`ifdef FIFO_REG_OUT_EN
  logic [W:0]   mem_cnt_r;
  logic [W:0]   mem_cnt_next_s;
  logic         out_valid_r;
  logic         out_valid_next_s;
  logic [B-1:0] out_data_r;

  // Refill the output register from the array whenever it is empty or being popped.
  assign mem_rd_s         = (mem_cnt_r != '0) & (~out_valid_r | rd_acc_s);
  assign out_valid_next_s = mem_rd_s | (out_valid_r & ~rd_acc_s);
  assign mem_cnt_next_s   = mem_cnt_r + (W+1)'(wr_acc_s) - (W+1)'(mem_rd_s);
  assign count_next_s     = mem_cnt_next_s + (W+1)'(out_valid_next_s);
  assign empty_next_s     = ~out_valid_next_s;
  assign r_data           = out_data_r;

  // Output stage: head word register and its valid bit, plus array occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      mem_cnt_r   <= '0;
    end else begin
      out_valid_r <= out_valid_next_s;
      mem_cnt_r   <= mem_cnt_next_s;
      if (mem_rd_s) begin
        out_data_r <= mem_r[r_ptr_r];
      end
    end
  end
`else
  assign mem_rd_s     = rd_acc_s;
  assign count_next_s = count_r + (W+1)'(wr_acc_s) - (W+1)'(rd_acc_s);
  assign empty_next_s = (count_next_s == '0);
  assign r_data       = mem_r[r_ptr_r];
`endif

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[w_ptr_r] <= w_data;
    end
  end

  // Read/write pointers wrap naturally at 2**W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_r <= '0;
      r_ptr_r <= '0;
    end else begin
      if (wr_acc_s) begin
        w_ptr_r <= w_ptr_r + 1'b1;
      end
      if (mem_rd_s) begin
        r_ptr_r <= r_ptr_r + 1'b1;
      end
    end
  end

  // Occupancy and status flags, all registered from the next-state count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r        <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      count_r        <= count_next_s;
      full_r         <= (count_next_s == CAP_C);
      empty_r        <= empty_next_s;
      almost_full_r  <= (count_next_s >= AF_C);
      almost_empty_r <= (count_next_s <= AE_C);
    end
  end

  // Sticky error flags: a new event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_evt_s | (overflow_r & ~clr_err);
      underflow_r <= unf_evt_s | (underflow_r & ~clr_err);
    end
  end

  assign count        = count_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
